vga_timing_gen: RTL and testbench

Raster timing generator feeding the VGA colour/output stage. It derives a pixel-rate clock enable from the board clock and runs horizontal/vertical counters. It issues early pixel coordinates so the downstream colour lookup can fetch data in advance. It also provides hs/vs/de delayed by a fixed pipeline latency so they line up with the colour data at the pins.

---
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel tick, early x/y request, delayed hs/vs/de.
// Define VGA_TIMING_PIX_DIV_EN to build the clk-to-pixel divider.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_DIV  = 8,
  parameter int LAT      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       req_valid,
  output logic       frame_start,
  output logic       hs,
  output logic       vs,
  output logic       de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [2:0] IDLE = {~HS_POL, ~VS_POL, 1'b0};

  logic [9:0] x_q;
  logic [9:0] y_q;
  logic       hs_req;
  logic       vs_req;
  logic [2:0] req_sig;
  logic [2:0] dly_out;

`ifdef VGA_TIMING_PIX_DIV_EN
  localparam logic [3:0] DIV_MAX = 4'(PIX_DIV - 1);

  logic [3:0] div_q;
  logic       ce_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      ce_q  <= (div_q == DIV_MAX);
      div_q <= (div_q == DIV_MAX) ? 4'd0 : div_q + 4'd1;
    end
  end

  assign pix_ce = ce_q;
`else
  assign pix_ce = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix_ce) begin
      if (x_q == X_MAX) begin
        x_q <= '0;
        y_q <= (y_q == Y_MAX) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign req_valid   = (x_q < H_ACT) && (y_q < V_ACT);
  assign frame_start = pix_ce && (x_q == 10'd0) && (y_q == 10'd0);

  assign hs_req  = (x_q >= HS_BEG && x_q <= HS_END) ? HS_POL : ~HS_POL;
  assign vs_req  = (y_q >= VS_BEG && y_q <= VS_END) ? VS_POL : ~VS_POL;
  assign req_sig = {hs_req, vs_req, req_valid};

  // Delay line lines sync/enable up with colour fetched from x/y.
  generate
    if (LAT == 0) begin : g_nodly
      assign dly_out = req_sig;
    end else begin : g_dly
      logic [2:0] pipe [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) pipe[i] <= IDLE;
        end else if (pix_ce) begin
          pipe[0] <= req_sig;
          for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly_out = pipe[LAT-1];
    end
  endgenerate

  assign {hs, vs, de} = dly_out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, LAT=2 and LAT=0 instances.
// Reference is tick-count arithmetic over the raster geometry.
module tb_vga_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 2;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int DIV = 4;
`ifdef VGA_TIMING_PIX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       ce2, rv2, fs2, hs2, vs2, de2;
  logic [9:0] x2, y2;
  logic       ce0, rv0, fs0, hs0, vs0, de0;
  logic [9:0] x0, y0;

  int passed = 0;
  int total  = 0;

  int t;
  int n;
  bit ce;
  bit tk;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(DIV), .LAT(2)
  ) dut_l2 (
    .clk(clk), .rst_n(rst_n), .pix_ce(ce2), .x(x2), .y(y2),
    .req_valid(rv2), .frame_start(fs2),
    .hs(hs2), .vs(vs2), .de(de2)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIX_DIV(DIV), .LAT(0)
  ) dut_l0 (
    .clk(clk), .rst_n(rst_n), .pix_ce(ce0), .x(x0), .y(y0),
    .req_valid(rv0), .frame_start(fs0),
    .hs(hs0), .vs(vs0), .de(de0)
  );

  // {hs,vs,de} the request stage shows at pixel tick s (s<0: idle).
  function automatic logic [2:0] req_at(int s, bit hp, bit vp);
    int xs, ys;
    logic h, v, d;
    if (s < 0) return {~hp, ~vp, 1'b0};
    xs = s % HT;
    ys = (s / HT) % VT;
    h = (xs >= HA + HF && xs < HA + HF + HS) ? hp : ~hp;
    v = (ys >= VA + VF && ys < VA + VF + VS) ? vp : ~vp;
    d = (xs < HA) && (ys < VA);
    return {h, v, d};
  endfunction

  task automatic model_reset();
    t = 0;
    n = 0;
    ce = DIV_EN ? 1'b0 : 1'b1;
  endtask

  task automatic clk_step();
    @(posedge clk);
    tk = ce;
    if (ce) t++;
    n++;
    ce = DIV_EN ? (n % DIV == 0) : 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] e0;
    bit ece;
    ece = DIV_EN ? 1'b0 : 1'b1;
    e0 = req_at(0, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({x2, y2} !== 20'd0) $display("FAIL rst_xy x=%0d y=%0d want 0 0", x2, y2);
    else passed++;
    total++;
    if ({ce2, rv2, fs2} !== {ece, 1'b1, ece})
      $display("FAIL rst_ctl ce/rv/fs=%b%b%b want %b1%b", ce2, rv2, fs2, ece, ece);
    else passed++;
    total++;
    if ({hs2, vs2, de2} !== 3'b110)
      $display("FAIL rst_dly2 hs/vs/de=%b%b%b want 110", hs2, vs2, de2);
    else passed++;
    total++;
    if ({hs0, vs0, de0} !== e0)
      $display("FAIL rst_dly0 hs/vs/de=%b%b%b want %b", hs0, vs0, de0, e0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_raster(int cycles);
    int ex, ey;
    bit erv, efs;
    logic [2:0] e2, e0;
    for (int i = 0; i < cycles; i++) begin
      clk_step();
      ex = t % HT;
      ey = (t / HT) % VT;
      erv = (ex < HA) && (ey < VA);
      efs = ce && ex == 0 && ey == 0;
      e2 = req_at(t - 2, 1'b0, 1'b0);
      e0 = req_at(t, 1'b1, 1'b0);
      total++;
      if (x2 !== 10'(ex) || y2 !== 10'(ey))
        $display("FAIL xy n=%0d x=%0d y=%0d want %0d %0d", n, x2, y2, ex, ey);
      else passed++;
      total++;
      if ({ce2, ce0} !== {ce, ce})
        $display("FAIL pix_ce n=%0d got %b%b want %b", n, ce2, ce0, ce);
      else passed++;
      total++;
      if ({rv2, fs2, rv0, fs0} !== {erv, efs, erv, efs})
        $display("FAIL rv_fs n=%0d got %b%b%b%b want %b%b",
                 n, rv2, fs2, rv0, fs0, erv, efs);
      else passed++;
      total++;
      if ({hs2, vs2, de2} !== e2)
        $display("FAIL lat2 t=%0d got %b%b%b want %b", t, hs2, vs2, de2, e2);
      else passed++;
      total++;
      if ({hs0, vs0, de0} !== e0 || x0 !== x2 || y0 !== y2)
        $display("FAIL lat0 t=%0d got %b%b%b want %b", t, hs0, vs0, de0, e0);
      else passed++;
    end
  endtask

  task automatic test_line();
    int rise = -1;
    int hs_on = -1;
    logic pde, phs;
    pde = de0;
    phs = hs0;
    for (int i = 0; i < 2 * FR * DIV + 8; i++) begin
      clk_step();
      if (tk) begin
        if (de0 && !pde) rise = t;
        if (!de0 && pde && rise >= 0) begin
          total++;
          if (t - rise !== HA) $display("FAIL de_width got %0d want %0d", t - rise, HA);
          else passed++;
        end
        if (hs0 && !phs) begin
          if (rise >= 0 && ((t / HT) % VT) < VA) begin
            total++;
            if (t - rise !== HA + HF)
              $display("FAIL hs_offset got %0d want %0d", t - rise, HA + HF);
            else passed++;
          end
          hs_on = t;
        end
        if (!hs0 && phs && hs_on >= 0) begin
          total++;
          if (t - hs_on !== HS) $display("FAIL hs_width got %0d want %0d", t - hs_on, HS);
          else passed++;
        end
        pde = de0;
        phs = hs0;
      end
    end
  endtask

  task automatic test_frame_start();
    int last = -1;
    int cnt = 0;
    for (int i = 0; i < (5 * FR * DIV) / 2; i++) begin
      clk_step();
      if (fs2) begin
        cnt++;
        total++;
        if (x2 !== 10'd0 || y2 !== 10'd0 || ce2 !== 1'b1)
          $display("FAIL fs_pos x=%0d y=%0d ce=%b want 0 0 1", x2, y2, ce2);
        else passed++;
        if (last >= 0) begin
          total++;
          if (t - last !== FR) $display("FAIL fs_period got %0d want %0d", t - last, FR);
          else passed++;
        end
        last = t;
      end
    end
    total++;
    if (cnt < 2) $display("FAIL fs_count got %0d want >=2", cnt);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int run;
    bit ece;
    ece = DIV_EN ? 1'b0 : 1'b1;
    run = $urandom_range(FR * DIV - 1, 40);
    for (int i = 0; i < run; i++) clk_step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({x2, y2, x0, y0} !== 40'd0)
      $display("FAIL mrst_xy x=%0d y=%0d want 0 0", x2, y2);
    else passed++;
    total++;
    if ({ce2, rv2, fs2, hs2, vs2, de2} !== {ece, 1'b1, ece, 3'b110})
      $display("FAIL mrst_out got %b%b%b%b%b%b want %b1%b110",
               ce2, rv2, fs2, hs2, vs2, de2, ece, ece);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({x2, y2, hs2, vs2, de2} !== {20'd0, 3'b110})
      $display("FAIL mrst_hold x=%0d y=%0d dly=%b%b%b", x2, y2, hs2, vs2, de2);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_raster($urandom_range(900, 300));
    test_line();
    test_frame_start();
    for (int k = 0; k < 3; k++) begin
      test_mid_reset();
      test_raster($urandom_range(700, 200));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
